// File: rtl/captura_pkg.sv
// Shared constants for the event capture block: event tags and default sizes.
// Imported by captura_fifo and captura_eventos.
package captura_pkg;

    localparam logic [1:0] TIPO_RCO   = 2'b01;
    localparam logic [1:0] TIPO_LOAD  = 2'b10;
    localparam logic [1:0] TIPO_AMBOS = 2'b11;

    localparam int W_DEF     = 32;
    localparam int DEPTH_DEF = 4;
    localparam int OVF_W_DEF = 8;
    localparam int TS_W      = 16;

    // Tag for the events seen in one cycle; 2'b00 means no event.
    function automatic logic [1:0] tipo_de(input logic ev_rco,
                                           input logic ev_load);
        logic [1:0] t;
        t = 2'b00;
        if (ev_rco && ev_load) t = TIPO_AMBOS;
        else if (ev_load)      t = TIPO_LOAD;
        else if (ev_rco)       t = TIPO_RCO;
        return t;
    endfunction

endpackage

// File: rtl/captura_fifo.sv
// Small FIFO with a registered head output, used by captura_eventos.
// Ports: clk, reset (async, active-low), push/din, pop, dout/valid, nivel, lleno.
module captura_fifo
    import captura_pkg::*;
#(
    parameter int PW    = 34,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [PW-1:0]              din,
    input  logic                       pop,
    output logic [PW-1:0]              dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     nivel,
    output logic                       lleno
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    logic [PW-1:0] mem_q [DEPTH];
    logic [PW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [NW-1:0] nivel_q, nivel_d;
    logic [PW-1:0] dout_q, dout_d;

    logic vacio;
    logic push_ok;
    logic pop_ok;

    assign vacio = (nivel_q == '0);
    assign lleno = (nivel_q == NW'(DEPTH));
    assign valid = ~vacio;
    assign nivel = nivel_q;
    assign dout  = dout_q;

    // A full FIFO still takes a push when the head leaves the same cycle.
    assign pop_ok  = pop & ~vacio;
    assign push_ok = push & (~lleno | pop_ok);

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_q] = din;
        rd_d    = rd_q + AW'(pop_ok);
        wr_d    = wr_q + AW'(push_ok);
        nivel_d = nivel_q + NW'(push_ok) - NW'(pop_ok);
        // Head register keeps the last popped value when nothing is left.
        dout_d = dout_q;
        if (nivel_d != '0) begin
            // Only an empty remainder makes rd_d meet wr_q: bypass din.
            if (push_ok && (rd_d == wr_q)) dout_d = din;
            else                           dout_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            nivel_q <= '0;
            dout_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            nivel_q <= nivel_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: rtl/captura_eventos.sv
// Captures counter value Q on rising edges of rco/load into a FIFO drained by valid/ready.
// Ports: clk, reset (async, active-low), enable_cap, rco_in, load_in, q_in,
//   out_valid/out_ready/out_data/out_tipo, nivel, lleno, overflow_cnt.
// Option CAPTURA_TIMESTAMP_EN adds a 16-bit cycle stamp per entry on out_ts.
module captura_eventos
    import captura_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int OVF_W = OVF_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable_cap,
    input  logic                       rco_in,
    input  logic                       load_in,
    input  logic [W-1:0]               q_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [1:0]                 out_tipo,
    output logic [$clog2(DEPTH):0]     nivel,
    output logic                       lleno,
`ifdef CAPTURA_TIMESTAMP_EN
    output logic [TS_W-1:0]            out_ts,
`endif
    output logic [OVF_W-1:0]           overflow_cnt
);

`ifdef CAPTURA_TIMESTAMP_EN
    localparam int PW = TS_W + W + 2;
`else
    localparam int PW = W + 2;
`endif

    logic rco_q, rco_d;
    logic load_q, load_d;
    logic arm_q, arm_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    logic ev_rco;
    logic ev_load;
    logic push;
    logic pop;
    logic drop;
    logic [1:0] tipo;
    logic [PW-1:0] din;
    logic [PW-1:0] dout;

    // arm_q blocks the first cycle after reset, so a level already high
    // at release is only sampled and a fresh 0->1 edge is needed.
    assign ev_rco  = arm_q & rco_in & ~rco_q;
    assign ev_load = arm_q & load_in & ~load_q;
    assign tipo    = tipo_de(ev_rco, ev_load);
    assign push    = enable_cap & (ev_rco | ev_load);
    assign pop     = out_valid & out_ready;
    assign drop    = push & lleno & ~pop;

`ifdef CAPTURA_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d = ts_q + 1'b1;
    assign din  = {ts_q, q_in, tipo};
    assign out_ts = dout[PW-1 -: TS_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_d;
    end
`else
    assign din = {q_in, tipo};
`endif

    assign out_data     = dout[W+1:2];
    assign out_tipo     = dout[1:0];
    assign overflow_cnt = ovf_q;

    always_comb begin
        rco_d  = rco_in;
        load_d = load_in;
        arm_d  = 1'b1;
        ovf_d  = ovf_q;
        if (drop && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rco_q  <= 1'b0;
            load_q <= 1'b0;
            arm_q  <= 1'b0;
            ovf_q  <= '0;
        end else begin
            rco_q  <= rco_d;
            load_q <= load_d;
            arm_q  <= arm_d;
            ovf_q  <= ovf_d;
        end
    end

    captura_fifo #(
        .PW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .valid (out_valid),
        .nivel (nivel),
        .lleno (lleno)
    );

endmodule

// File: tb/tb_captura_eventos.sv
// Self-checking bench for captura_eventos: queue-based reference model,
// per-cycle compare, directed scenarios with literal expectations, random run.
module tb_captura_eventos;

    localparam int DEPTH = 4;
    localparam int OVF_MAX = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable_cap = 1'b0;
    logic        rco_in = 1'b0;
    logic        load_in = 1'b0;
    logic [31:0] q_in = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_tipo;
    logic [2:0]  nivel;
    logic        lleno;
    logic [7:0]  overflow_cnt;
`ifdef CAPTURA_TIMESTAMP_EN
    logic [15:0] out_ts;
`endif

    always #5 clk = ~clk;

    captura_eventos dut (
        .clk          (clk),
        .reset        (reset),
        .enable_cap   (enable_cap),
        .rco_in       (rco_in),
        .load_in      (load_in),
        .q_in         (q_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tipo     (out_tipo),
        .nivel        (nivel),
        .lleno        (lleno),
`ifdef CAPTURA_TIMESTAMP_EN
        .out_ts       (out_ts),
`endif
        .overflow_cnt (overflow_cnt)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string n, input logic [63:0] a,
                         input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: queue of captured entries plus history of inputs.
    typedef struct {
        logic [31:0] d;
        logic [1:0]  t;
        logic [15:0] ts;
    } ent_t;

    ent_t        mq[$];
    ent_t        last = '{32'd0, 2'd0, 16'd0};
    bit          armed = 0;
    bit          prev_r = 0;
    bit          prev_l = 0;
    int          ovf = 0;
    logic [15:0] ts_m = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            last   = '{32'd0, 2'd0, 16'd0};
            armed  = 0;
            prev_r = 0;
            prev_l = 0;
            ovf    = 0;
            ts_m   = '0;
        end else begin
            bit er, el, pu, po;
            ent_t e;
            er = armed && rco_in && !prev_r;
            el = armed && load_in && !prev_l;
            pu = enable_cap && (er || el);
            po = (mq.size() > 0) && out_ready;
            e.d  = q_in;
            e.t  = {el, er};
            e.ts = ts_m;
            if (po) last = mq.pop_front();
            if (pu) begin
                if (mq.size() < DEPTH) mq.push_back(e);
                else if (ovf < OVF_MAX) ovf++;
            end
            prev_r = rco_in;
            prev_l = load_in;
            armed  = 1;
            ts_m   = ts_m + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            ent_t h;
            h = (mq.size() > 0) ? mq[0] : last;
            check("valid", 64'(out_valid), 64'(mq.size() > 0));
            check("data", 64'(out_data), 64'(h.d));
            check("tipo", 64'(out_tipo), 64'(h.t));
            check("nivel", 64'(nivel), 64'(mq.size()));
            check("lleno", 64'(lleno), 64'(mq.size() == DEPTH));
            check("ovf", 64'(overflow_cnt), 64'(ovf));
`ifdef CAPTURA_TIMESTAMP_EN
            if (mq.size() > 0) check("ts", 64'(out_ts), 64'(h.ts));
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic edge_rco(input logic [31:0] v);
        rco_in = 1'b1;
        q_in   = v;
        cyc();
        rco_in = 1'b0;
        cyc();
    endtask

    initial begin
        logic [31:0] exp_d[4];
        enable_cap = 1'b1;
        repeat (3) cyc();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_nivel", 64'(nivel), 64'd0);
        check("rst_ovf", 64'(overflow_cnt), 64'd0);
        reset = 1'b1;
        cyc();

        // 1: single rco pulse
        rco_in = 1'b1;
        q_in   = 32'h0000_000F;
        cyc();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'h0000_000F);
        check("t1_tipo", 64'(out_tipo), 64'd1);
        rco_in    = 1'b0;
        out_ready = 1'b1;
        cyc();
        check("t1_empty", 64'(out_valid), 64'd0);
        check("t1_hold", 64'(out_data), 64'h0000_000F);
        out_ready = 1'b0;

        // 2: rco and load together -> one entry tagged 11
        rco_in  = 1'b1;
        load_in = 1'b1;
        q_in    = 32'h1234_5678;
        cyc();
        check("t2_tipo", 64'(out_tipo), 64'd3);
        check("t2_nivel", 64'(nivel), 64'd1);
        check("t2_data", 64'(out_data), 64'h1234_5678);
        rco_in    = 1'b0;
        load_in   = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // 3: five edges into a 4-deep FIFO
        for (int i = 0; i < 5; i++) edge_rco(32'h100 + i);
        check("t3_nivel", 64'(nivel), 64'd4);
        check("t3_lleno", 64'(lleno), 64'd1);
        check("t3_ovf", 64'(overflow_cnt), 64'd1);

        // 4: full, push and pop together
        rco_in    = 1'b1;
        q_in      = 32'hAAA;
        out_ready = 1'b1;
        cyc();
        rco_in = 1'b0;
        check("t4_nivel", 64'(nivel), 64'd4);
        check("t4_ovf", 64'(overflow_cnt), 64'd1);
        exp_d = '{32'h101, 32'h102, 32'h103, 32'hAAA};
        for (int i = 0; i < 4; i++) begin
            check("t4_drain_v", 64'(out_valid), 64'd1);
            check("t4_drain_d", 64'(out_data), 64'(exp_d[i]));
            cyc();
        end
        check("t4_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // overflow counter saturation
        for (int i = 0; i < 270; i++) edge_rco(32'(i));
        check("sat_ovf", 64'(overflow_cnt), 64'd255);
        out_ready = 1'b1;
        repeat (6) cyc();
        out_ready = 1'b0;

        // 5: reset mid-stream
        edge_rco(32'h55);
        edge_rco(32'h66);
        #2 reset = 1'b0;
        #1;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_nivel", 64'(nivel), 64'd0);
        check("t5_ovf", 64'(overflow_cnt), 64'd0);
        rco_in = 1'b1;
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        check("t5_nocap", 64'(nivel), 64'd0);
        rco_in = 1'b0;
        cyc();
        rco_in = 1'b1;
        q_in   = 32'h77;
        cyc();
        check("t5_fresh", 64'(nivel), 64'd1);
        rco_in    = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            enable_cap = ($urandom % 8) != 0;
            rco_in     = ($urandom % 3) == 0;
            load_in    = ($urandom % 5) == 0;
            out_ready  = ($urandom % 2) == 1;
            q_in       = $urandom;
            cyc();
        end
        enable_cap = 1'b1;
        rco_in     = 1'b0;
        load_in    = 1'b0;
        out_ready  = 1'b0;

`ifdef CAPTURA_TIMESTAMP_EN
        // 6: timestamps of edges at cycles 3 and 10 after release
        cyc();
        #2 reset = 1'b0;
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        rco_in = 1'b1;
        q_in   = 32'h3;
        cyc();
        rco_in = 1'b0;
        repeat (6) cyc();
        rco_in = 1'b1;
        q_in   = 32'hA;
        cyc();
        rco_in = 1'b0;
        check("t6_ts0", 64'(out_ts), 64'd3);
        out_ready = 1'b1;
        cyc();
        check("t6_ts1", 64'(out_ts), 64'd10);
        cyc();
        out_ready = 1'b0;
`endif

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
